// File: rtl/coin_mem_pkg.sv
// Shared constants for the vending-machine money accumulator:
// coin codes and values, product selects, sales phases and default prices.
package coin_mem_pkg;

  localparam int unsigned COIN_W = 3;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned ST_W   = 2;
  localparam int unsigned AMT_W  = 8;

  localparam logic [COIN_W-1:0] COIN_1  = 3'b001;
  localparam logic [COIN_W-1:0] COIN_5  = 3'b010;
  localparam logic [COIN_W-1:0] COIN_10 = 3'b100;

  localparam logic [AMT_W-1:0] COIN_VAL_1  = 8'd1;
  localparam logic [AMT_W-1:0] COIN_VAL_5  = 8'd5;
  localparam logic [AMT_W-1:0] COIN_VAL_10 = 8'd10;

  localparam logic [SEL_W-1:0] SEL_A = 2'b10;
  localparam logic [SEL_W-1:0] SEL_B = 2'b01;

  localparam logic [AMT_W-1:0] DEF_PRICE_A = 8'd2;
  localparam logic [AMT_W-1:0] DEF_PRICE_B = 8'd3;

  typedef enum logic [ST_W-1:0] {
    ST_TRADE    = 2'b00,
    ST_HOLD     = 2'b01,
    ST_CLEAR    = 2'b10,
    ST_HOLD_ALT = 2'b11
  } sales_state_e;

  // Face value of a coin code; invalid codes are worth nothing.
  function automatic logic [AMT_W-1:0] coin_value(input logic [COIN_W-1:0] code);
    case (code)
      COIN_1:  coin_value = COIN_VAL_1;
      COIN_5:  coin_value = COIN_VAL_5;
      COIN_10: coin_value = COIN_VAL_10;
      default: coin_value = '0;
    endcase
  endfunction

endpackage

// File: rtl/coin_mem_if.sv
// Coin/select/phase inputs and money outputs of coin_mem.
interface coin_mem_if;
  import coin_mem_pkg::*;

  logic [SEL_W-1:0]  ab;
  logic [COIN_W-1:0] coin;
  logic [ST_W-1:0]   state;
  logic [AMT_W-1:0]  cost;
  logic [AMT_W-1:0]  left;
  logic              overflow;

  modport master (output ab, coin, state, input cost, left, overflow);
  modport slave  (input ab, coin, state, output cost, left, overflow);

endinterface

// File: rtl/coin_mem_edge_det.sv
// Change detector: pulses when the input is nonzero and differs from the
// value registered at the previous edge.
module coin_edge_det #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic         pulse_c
);

  logic [W-1:0] prev_q;

  always_ff @(posedge clk) begin
    if (reset) prev_q <= '0;
    else       prev_q <= d;
  end

  assign pulse_c = (|d) && (d != prev_q);

endmodule

// File: rtl/coin_mem.sv
// Money accumulator: running balance and spend from coin/select events.
// Define COIN_MEM_STICKY_OVF_EN to make overflow hold until reset or CLEAR.
module coin_mem
  import coin_mem_pkg::*;
#(
  parameter logic [AMT_W-1:0] PRICE_A = DEF_PRICE_A,
  parameter logic [AMT_W-1:0] PRICE_B = DEF_PRICE_B
) (
  input  logic       clk,
  input  logic       reset,
  coin_mem_if.slave  bus
);

  logic [AMT_W-1:0] cost_q, left_q;
  logic             ovf_q;
  logic [AMT_W-1:0] cost_n, left_n;
  logic             ovf_n;

  logic             coin_pulse_c, sel_pulse_c;
  logic             coin_ev, buy_ev;
  logic [AMT_W-1:0] coin_val, price, bal;
  logic [AMT_W:0]   coin_sum, cost_sum;
  logic             coin_rej, buy_ok, rej;
  sales_state_e     st;

  coin_edge_det #(.W(COIN_W)) u_coin_det (
    .clk(clk), .reset(reset), .d(bus.coin), .pulse_c(coin_pulse_c)
  );

  coin_edge_det #(.W(SEL_W)) u_sel_det (
    .clk(clk), .reset(reset), .d(bus.ab), .pulse_c(sel_pulse_c)
  );

  assign st = sales_state_e'(bus.state);

  // Coin is applied first; the purchase sees the post-coin balance.
  always_comb begin
    coin_val = coin_value(bus.coin);
    price    = '0;
    case (bus.ab)
      SEL_A:   price = PRICE_A;
      SEL_B:   price = PRICE_B;
      default: price = '0;
    endcase

    coin_ev  = coin_pulse_c && (coin_val != '0);
    buy_ev   = sel_pulse_c && (price != '0);
    coin_sum = {1'b0, left_q} + {1'b0, coin_val};
    coin_rej = coin_ev && coin_sum[AMT_W];
    bal      = (coin_ev && !coin_sum[AMT_W]) ? coin_sum[AMT_W-1:0] : left_q;
    buy_ok   = buy_ev && (price <= bal);
    cost_sum = {1'b0, cost_q} + {1'b0, price};
    rej      = coin_rej || (buy_ev && !buy_ok);

    cost_n = cost_q;
    left_n = left_q;
`ifdef COIN_MEM_STICKY_OVF_EN
    ovf_n  = ovf_q;
`else
    ovf_n  = 1'b0;
`endif

    case (st)
      ST_TRADE: begin
        left_n = buy_ok ? AMT_W'(bal - price) : bal;
        if (buy_ok) cost_n = cost_sum[AMT_W] ? '1 : cost_sum[AMT_W-1:0];
        if (rej)    ovf_n  = 1'b1;
      end
      ST_CLEAR: begin
        cost_n = '0;
        left_n = '0;
        ovf_n  = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cost_q <= '0;
      left_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      cost_q <= cost_n;
      left_q <= left_n;
      ovf_q  <= ovf_n;
    end
  end

  assign bus.cost     = cost_q;
  assign bus.left     = left_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_coin_mem.sv
// Directed vector bench for coin_mem (both overflow builds).
module tb_coin_mem;

  logic clk = 1'b0;
  logic reset;
  coin_mem_if bus();

  coin_mem dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic [2:0] c;
    logic [1:0] a;
    logic [1:0] s;
    logic [7:0] ec;
    logic [7:0] el;
    logic       eo;
    logic       eos;
    string      nm;
  } vec_t;

  vec_t tbl[$];
  vec_t tbl2[$];
  int   nvec = 0;
  int   nmis = 0;

  function automatic vec_t mk(logic r, logic [2:0] c, logic [1:0] a, logic [1:0] s,
                              logic [7:0] ec, logic [7:0] el, logic eo, logic eos,
                              string nm);
    vec_t v;
    v.r = r; v.c = c; v.a = a; v.s = s;
    v.ec = ec; v.el = el; v.eo = eo; v.eos = eos; v.nm = nm;
    return v;
  endfunction

  // Drive one edge worth of inputs, then check the registered result.
  task automatic step(input vec_t v);
    logic eo;
`ifdef COIN_MEM_STICKY_OVF_EN
    eo = v.eos;
`else
    eo = v.eo;
`endif
    reset     = v.r;
    bus.coin  = v.c;
    bus.ab    = v.a;
    bus.state = v.s;
    @(posedge clk);
    #1;
    nvec++;
    if (bus.cost !== v.ec || bus.left !== v.el || bus.overflow !== eo) begin
      nmis++;
      $display("FAIL %s: got cost=%0d left=%0d ovf=%0b, want cost=%0d left=%0d ovf=%0b",
               v.nm, bus.cost, bus.left, bus.overflow, v.ec, v.el, eo);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Insertion, purchases, rejected purchase, CLEAR
    tbl.push_back(mk(1, 3'b000, 2'b00, 2'b00, 0,  0, 0, 0, "reset"));
    tbl.push_back(mk(0, 3'b001, 2'b00, 2'b00, 0,  1, 0, 0, "coin1"));
    tbl.push_back(mk(0, 3'b001, 2'b00, 2'b00, 0,  1, 0, 0, "coin1_held_a"));
    tbl.push_back(mk(0, 3'b001, 2'b00, 2'b00, 0,  1, 0, 0, "coin1_held_b"));
    tbl.push_back(mk(0, 3'b100, 2'b00, 2'b00, 0, 11, 0, 0, "coin10_direct"));
    tbl.push_back(mk(0, 3'b100, 2'b00, 2'b00, 0, 11, 0, 0, "coin10_held"));
    tbl.push_back(mk(0, 3'b000, 2'b00, 2'b00, 0, 11, 0, 0, "coin_idle"));
    tbl.push_back(mk(0, 3'b000, 2'b10, 2'b00, 2,  9, 0, 0, "buy_a"));
    tbl.push_back(mk(0, 3'b000, 2'b01, 2'b00, 5,  6, 0, 0, "buy_b"));
    tbl.push_back(mk(0, 3'b000, 2'b10, 2'b00, 7,  4, 0, 0, "buy_a2"));
    tbl.push_back(mk(0, 3'b000, 2'b00, 2'b00, 7,  4, 0, 0, "sel_idle"));
    tbl.push_back(mk(0, 3'b000, 2'b10, 2'b00, 9,  2, 0, 0, "buy_a3"));
    tbl.push_back(mk(0, 3'b000, 2'b00, 2'b00, 9,  2, 0, 0, "sel_idle2"));
    tbl.push_back(mk(0, 3'b000, 2'b01, 2'b00, 9,  2, 1, 1, "buy_b_short"));
    tbl.push_back(mk(0, 3'b000, 2'b00, 2'b00, 9,  2, 0, 1, "ovf_after"));
    tbl.push_back(mk(0, 3'b000, 2'b00, 2'b10, 0,  0, 0, 0, "clear"));

    // Near-full balance, HOLD, simultaneous events, mid-sequence reset
    tbl2.push_back(mk(0, 3'b100, 2'b00, 2'b00, 0, 250, 1, 1, "coin10_overfill"));
    tbl2.push_back(mk(0, 3'b000, 2'b00, 2'b00, 0, 250, 0, 1, "overfill_after"));
    tbl2.push_back(mk(0, 3'b010, 2'b00, 2'b00, 0, 255, 0, 1, "coin5_to_255"));
    tbl2.push_back(mk(0, 3'b000, 2'b00, 2'b00, 0, 255, 0, 1, "full_idle"));
    tbl2.push_back(mk(0, 3'b001, 2'b00, 2'b00, 0, 255, 1, 1, "coin1_overfill"));
    tbl2.push_back(mk(0, 3'b000, 2'b00, 2'b01, 0, 255, 0, 1, "hold_idle"));
    tbl2.push_back(mk(0, 3'b001, 2'b00, 2'b01, 0, 255, 0, 1, "hold_coin"));
    tbl2.push_back(mk(0, 3'b001, 2'b10, 2'b11, 0, 255, 0, 1, "hold11_sel"));
    tbl2.push_back(mk(0, 3'b001, 2'b10, 2'b00, 0, 255, 0, 1, "trade_held_codes"));
    tbl2.push_back(mk(0, 3'b000, 2'b00, 2'b10, 0,   0, 0, 0, "clear2"));
    tbl2.push_back(mk(0, 3'b010, 2'b01, 2'b00, 3,   2, 0, 0, "coin5_and_buy_b"));
    tbl2.push_back(mk(0, 3'b001, 2'b10, 2'b00, 5,   1, 0, 0, "coin1_and_buy_a"));
    tbl2.push_back(mk(0, 3'b010, 2'b01, 2'b00, 8,   3, 0, 0, "coin5_and_buy_b2"));
    tbl2.push_back(mk(1, 3'b100, 2'b00, 2'b00, 0,   0, 0, 0, "mid_reset"));
    tbl2.push_back(mk(0, 3'b100, 2'b00, 2'b00, 0,  10, 0, 0, "first_after_reset"));
    tbl2.push_back(mk(0, 3'b100, 2'b01, 2'b00, 3,   7, 0, 0, "buy_after_reset"));

    foreach (tbl[i]) step(tbl[i]);

    // Fill to 250 with pulsed 10-yuan coins
    for (int k = 1; k <= 25; k++) begin
      step(mk(0, 3'b100, 2'b00, 2'b00, 0, 8'(k * 10), 0, 0, $sformatf("fill_%0d", k)));
      step(mk(0, 3'b000, 2'b00, 2'b00, 0, 8'(k * 10), 0, 0, $sformatf("fill_gap_%0d", k)));
    end

    foreach (tbl2[i]) step(tbl2[i]);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
